// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory request arbiter.
package mem_req_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    localparam int TIMEOUT_CYC_DEF = 1023;

endpackage

// File: rtl/mem_req_arbiter_llsc_resv.sv
// Load-linked reservation: one valid bit plus the reserved word address.
module llsc_resv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_i,
    input  logic        clr_i,
    input  logic [29:0] set_addr_i,
    input  logic [29:0] cmp_addr_i,
    output logic        match_o
);

    logic        valid_q, valid_d;
    logic [29:0] addr_q, addr_d;

    // A clear in the same cycle as a set leaves the reservation invalid.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (set_i) begin
            valid_d = 1'b1;
            addr_d  = set_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign match_o = valid_q && (addr_q == cmp_addr_i);

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory bus with completion timeout.
// Optional LL/SC reservation tracking is enabled by defining MEM_ARB_LLSC_EN.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no bus cycle; sample requests, data port has priority
//   ST_BUSY | mem_en high, mem_* frozen; wait for mem_done or timeout
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_ll,
    input  logic        d_sc,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_sc_ok,
    output logic        bus_err,
    input  logic        llbit_clr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sel_n,
    output logic        mem_en,
    output logic        mem_wen_n,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e       state_q, state_d;
    port_e            port_q, port_d;
    logic             wr_q, wr_d, sc_q, sc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_sel_n_q, mem_sel_n_d;
    logic             mem_wen_n_q, mem_wen_n_d;
    logic             if_ack_q, if_ack_d, d_ack_q, d_ack_d;
    logic [31:0]      if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic             d_sc_ok_q, d_sc_ok_d, bus_err_q, bus_err_d;

    logic d_pend, if_pend, in_idle, d_take, if_take, finish, tout, sc_fail;

    // A port is masked during its own ack cycle so its still-high request is not re-taken.
    assign d_pend  = d_req & ~d_ack_q;
    assign if_pend = if_req & ~if_ack_q;
    assign in_idle = (state_q == ST_IDLE);
    assign d_take  = in_idle & d_pend & ~sc_fail;
    assign if_take = in_idle & ~d_pend & if_pend;
    assign finish  = (state_q == ST_BUSY) & (mem_done | (cnt_q == '0));
    assign tout    = finish & ~mem_done;

`ifdef MEM_ARB_LLSC_EN
    logic ll_q, ll_d, resv_ok, resv_set, resv_clr;
    logic unused_in;

    assign unused_in = ^{if_addr[1:0], d_addr[1:0]};
    assign ll_d      = d_take ? d_ll : ll_q;
    assign sc_fail   = in_idle & d_pend & d_sc & ~resv_ok;
    assign resv_set  = finish & mem_done & (port_q == PORT_D) & ll_q;
    assign resv_clr  = llbit_clr | sc_fail | (finish & (port_q == PORT_D) & sc_q);

    always_ff @(posedge clk) begin
        if (!rst_n) ll_q <= 1'b0;
        else        ll_q <= ll_d;
    end

    llsc_resv u_llsc_resv (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (resv_set),
        .clr_i      (resv_clr),
        .set_addr_i (mem_addr_q[31:2]),
        .cmp_addr_i (d_addr[31:2]),
        .match_o    (resv_ok)
    );
`else
    logic unused_in;

    assign unused_in = ^{if_addr[1:0], d_addr[1:0], d_ll, llbit_clr};
    assign sc_fail   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        wr_d        = wr_q;
        sc_d        = sc_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_sel_n_d = mem_sel_n_q;
        mem_wen_n_d = mem_wen_n_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = '0;
        d_ack_d     = 1'b0;
        d_rdata_d   = '0;
        d_sc_ok_d   = 1'b0;
        bus_err_d   = 1'b0;
        if (d_take) begin
            state_d     = ST_BUSY;
            port_d      = PORT_D;
            wr_d        = d_we | d_sc;
            sc_d        = d_sc;
            cnt_d       = CNT_LOAD;
            mem_addr_d  = {d_addr[31:2], 2'b00};
            mem_wdata_d = d_wdata;
            mem_sel_n_d = ~d_be;
            mem_wen_n_d = ~(d_we | d_sc);
        end else if (if_take) begin
            state_d     = ST_BUSY;
            port_d      = PORT_IF;
            wr_d        = 1'b0;
            sc_d        = 1'b0;
            cnt_d       = CNT_LOAD;
            mem_addr_d  = {if_addr[31:2], 2'b00};
            mem_wdata_d = '0;
            mem_sel_n_d = 4'b0000;
            mem_wen_n_d = 1'b1;
        end else if (sc_fail) begin
            d_ack_d = 1'b1;
        end else if (finish) begin
            state_d   = ST_IDLE;
            bus_err_d = tout;
            if (port_q == PORT_D) begin
                d_ack_d   = 1'b1;
                d_rdata_d = (tout | wr_q) ? '0 : mem_rdata;
                d_sc_ok_d = sc_q;
            end else begin
                if_ack_d   = 1'b1;
                if_rdata_d = tout ? '0 : mem_rdata;
            end
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            port_q      <= PORT_IF;
            wr_q        <= 1'b0;
            sc_q        <= 1'b0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_sel_n_q <= 4'hF;
            mem_wen_n_q <= 1'b1;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_sc_ok_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            wr_q        <= wr_d;
            sc_q        <= sc_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_sel_n_q <= mem_sel_n_d;
            mem_wen_n_q <= mem_wen_n_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            d_sc_ok_q   <= d_sc_ok_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_en    = (state_q == ST_BUSY);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_sel_n = mem_sel_n_q;
    assign mem_wen_n = mem_wen_n_q;
    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_sc_ok   = d_sc_ok_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: scoreboarded bus cycles and responses.
module tb_mem_req_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, d_ll, d_sc, llbit_clr, mem_done;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ack, d_ack, d_sc_ok, bus_err, mem_en, mem_wen_n;
    logic [3:0]  mem_sel_n;

    always #5 clk = ~clk;

    mem_req_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_ll(d_ll), .d_sc(d_sc), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_be(d_be), .d_rdata(d_rdata), .d_ack(d_ack),
        .d_sc_ok(d_sc_ok), .bus_err(bus_err), .llbit_clr(llbit_clr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel_n(mem_sel_n),
        .mem_en(mem_en), .mem_wen_n(mem_wen_n), .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    typedef struct { logic is_d; logic [31:0] rdata; logic err; logic sc_ok; } rsp_t;
    typedef struct { logic [31:0] addr; logic [3:0] sel_n; logic wen_n; logic [31:0] wdata; } mem_t;

    rsp_t rsp_q[$];
    mem_t mem_q[$];
    int   n_cmp = 0, n_mis = 0;
    int   resp_dly = 3, spur_req = 0;
    logic [31:0] resp_data = '0;
    int   issues = 0, hi_run = 0, low_run = 0, last_len = 0, last_gap = 0;
    logic en_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, want);
        end
    endtask

    // Responder: completes each bus cycle resp_dly cycles after mem_en rises (0 = never).
    initial begin : responder
        int busy_cnt;
        int spur_ack;
        busy_cnt  = 0;
        spur_ack  = 0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_done) begin
                mem_done = 1'b0;
                busy_cnt = 0;
            end else if (mem_en === 1'b1) begin
                busy_cnt++;
                if (resp_dly != 0 && busy_cnt == resp_dly) begin
                    mem_done  = 1'b1;
                    mem_rdata = resp_data;
                end
            end else begin
                busy_cnt = 0;
                if (spur_req != spur_ack) begin
                    spur_ack  = spur_req;
                    mem_done  = 1'b1;
                    mem_rdata = 32'hFFFF_FFFF;
                end
            end
        end
    end

    mem_t cur_m;
    rsp_t mon_r;
    logic mon_en_prev = 1'b0, mon_ack_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            if (!mon_en_prev) begin
                chk("mem_cycle_expected", 32'(mem_q.size() != 0), 32'd1);
                if (mem_q.size() != 0) begin
                    cur_m = mem_q.pop_front();
                    chk("mem_addr", mem_addr, cur_m.addr);
                    chk("mem_sel_n", 32'(mem_sel_n), 32'(cur_m.sel_n));
                    chk("mem_wen_n", 32'(mem_wen_n), 32'(cur_m.wen_n));
                    if (cur_m.wen_n == 1'b0) chk("mem_wdata", mem_wdata, cur_m.wdata);
                end
            end else begin
                chk("mem_addr_stable", mem_addr, cur_m.addr);
                chk("mem_sel_n_stable", 32'(mem_sel_n), 32'(cur_m.sel_n));
            end
        end
        if ((if_ack | d_ack) === 1'b1) begin
            chk("ack_exclusive", 32'(if_ack & d_ack), 32'd0);
            chk("ack_one_cycle", 32'(mon_ack_prev), 32'd0);
            chk("ack_mem_en_low", 32'(mem_en), 32'd0);
            chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
            if (rsp_q.size() != 0) begin
                mon_r = rsp_q.pop_front();
                chk("rsp_port", 32'(d_ack), 32'(mon_r.is_d));
                chk("rsp_rdata", (d_ack === 1'b1) ? d_rdata : if_rdata, mon_r.rdata);
                chk("rsp_bus_err", 32'(bus_err), 32'(mon_r.err));
                chk("rsp_sc_ok", 32'(d_sc_ok), 32'(mon_r.sc_ok));
            end
        end
        mon_ack_prev = ((if_ack | d_ack) === 1'b1);
        mon_en_prev  = (mem_en === 1'b1);
    end

    task automatic tick();
        @(posedge clk); #1;
        if (if_ack === 1'b1) if_req = 1'b0;
        if (d_ack === 1'b1) d_req = 1'b0;
        if (mem_en === 1'b1) begin
            if (!en_prev) begin
                issues++;
                last_gap = low_run;
            end
            hi_run++;
            low_run = 0;
        end else begin
            if (en_prev) last_len = hi_run;
            hi_run = 0;
            low_run++;
        end
        en_prev = (mem_en === 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && ((if_req | d_req | mem_en | if_ack | d_ack) === 1'b1)) begin
            tick();
            n++;
        end
        chk(tag, 32'((if_req | d_req | mem_en) === 1'b1), 32'd0);
        tick();
    endtask

    task automatic d_op(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                        input logic we, input logic ll, input logic sc, input logic exp_mem,
                        input logic [31:0] exp_rdata, input logic exp_ok, input logic exp_err);
        int iss0;
        iss0 = issues;
        if (exp_mem) mem_q.push_back(mem_t'{{addr[31:2], 2'b00}, ~be, ~(we | sc), wdata});
        rsp_q.push_back(rsp_t'{1'b1, exp_rdata, exp_err, exp_ok});
        d_addr = addr; d_wdata = wdata; d_be = be; d_we = we; d_ll = ll; d_sc = sc; d_req = 1'b1;
        tick();
        if (exp_mem) chk("d_en_latency", 32'(mem_en), 32'd1);
        else         chk("sc_fail_ack_latency", 32'(d_ack), 32'd1);
        wait_idle("d_op_bounded", 60);
        d_we = 1'b0; d_ll = 1'b0; d_sc = 1'b0;
        chk("d_op_mem_cycles", 32'(issues - iss0), 32'(exp_mem));
    endtask

    initial begin
        int iss0;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_ll = 1'b0;
        d_sc = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0; llbit_clr = 1'b0;
        tick(); tick(); tick();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_wen_n", 32'(mem_wen_n), 32'd1);
        chk("rst_mem_sel_n", 32'(mem_sel_n), 32'hF);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_acks", 32'({if_ack, d_ack, d_sc_ok, bus_err}), 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // single fetch, unaligned address
        resp_dly = 3; resp_data = 32'h1234_5678;
        mem_q.push_back(mem_t'{32'h8000_0004, 4'h0, 1'b1, 32'h0});
        rsp_q.push_back(rsp_t'{1'b0, 32'h1234_5678, 1'b0, 1'b0});
        if_addr = 32'h8000_0006; if_req = 1'b1;
        chk("fetch_en_before", 32'(mem_en), 32'd0);
        tick();
        chk("fetch_en_latency", 32'(mem_en), 32'd1);
        wait_idle("fetch_bounded", 20);
        chk("fetch_busy_len", 32'(last_len), 32'd3);

        // simultaneous requests: data store wins, fetch follows after a one-cycle gap
        resp_dly = 2; resp_data = 32'h55AA_33CC;
        mem_q.push_back(mem_t'{32'h0000_0104, 4'b1100, 1'b0, 32'hCAFE_BABE});
        mem_q.push_back(mem_t'{32'h0000_2000, 4'b0000, 1'b1, 32'h0});
        rsp_q.push_back(rsp_t'{1'b1, 32'h0, 1'b0, 1'b0});
        rsp_q.push_back(rsp_t'{1'b0, 32'h55AA_33CC, 1'b0, 1'b0});
        d_addr = 32'h0000_0105; d_wdata = 32'hCAFE_BABE; d_be = 4'b0011; d_we = 1'b1; d_req = 1'b1;
        if_addr = 32'h0000_2003; if_req = 1'b1;
        wait_idle("arb_bounded", 40);
        d_we = 1'b0;
        chk("arb_gap", 32'(last_gap), 32'd1);

        // data load with sparse byte enables
        resp_dly = 1; resp_data = 32'hDEAD_0001;
        d_op(32'h1000_000B, 32'h0, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0001, 1'b0, 1'b0);

        // timeouts on both ports
        resp_dly = 0; resp_data = 32'h0BAD_BEEF;
        mem_q.push_back(mem_t'{32'h0000_0040, 4'h0, 1'b1, 32'h0});
        rsp_q.push_back(rsp_t'{1'b0, 32'h0, 1'b1, 1'b0});
        if_addr = 32'h0000_0040; if_req = 1'b1;
        wait_idle("fetch_timeout_bounded", 40);
        chk("timeout_busy_len", 32'(last_len), 32'(TO));
        d_op(32'h0000_0044, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        chk("d_timeout_busy_len", 32'(last_len), 32'(TO));

        // mem_done while idle must be ignored
        iss0 = issues;
        spur_req++;
        repeat (4) tick();
        chk("spurious_done_no_cycle", 32'(issues - iss0), 32'd0);

        // LL / SC sequences
        resp_dly = 1; resp_data = 32'h0BAD_F00D;
        d_op(32'h8040_0000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
        d_op(32'h8040_0000, 32'hA5A5_0001, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
`ifdef MEM_ARB_LLSC_EN
        d_op(32'h8040_0000, 32'hA5A5_0002, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
`else
        d_op(32'h8040_0000, 32'hA5A5_0002, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
`endif
        d_op(32'h8040_0000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
        llbit_clr = 1'b1;
        tick();
        llbit_clr = 1'b0;
`ifdef MEM_ARB_LLSC_EN
        d_op(32'h8040_0000, 32'hA5A5_0003, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
`else
        d_op(32'h8040_0000, 32'hA5A5_0003, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
`endif

        // reset while busy: no ack, request reissued after release
        resp_dly = 0; resp_data = 32'h7777_0000;
        mem_q.push_back(mem_t'{32'h2222_2220, 4'h0, 1'b1, 32'h0});
        mem_q.push_back(mem_t'{32'h2222_2220, 4'h0, 1'b1, 32'h0});
        rsp_q.push_back(rsp_t'{1'b1, 32'h7777_0000, 1'b0, 1'b0});
        iss0 = issues;
        d_addr = 32'h2222_2222; d_be = 4'hF; d_req = 1'b1;
        tick();
        chk("rstbusy_en", 32'(mem_en), 32'd1);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("rstbusy_en_drop", 32'(mem_en), 32'd0);
        chk("rstbusy_no_ack", 32'(d_ack), 32'd0);
        chk("rstbusy_sel_n", 32'(mem_sel_n), 32'hF);
        resp_dly = 2;
        rst_n = 1'b1;
        wait_idle("rstbusy_bounded", 40);
        chk("rstbusy_reissue", 32'(issues - iss0), 32'd2);

        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
